// File: rtl/hpc1_and_pipe_if.sv
// Handshake and share bundle for the HPC1 AND pipeline.
// The master side supplies operand shares and randomness; the slave side returns result shares.
interface hpc1_and_pipe_if #(
  parameter int W = 4,
  parameter int K = 2
);
  logic [W-1:0]   a0;
  logic [W-1:0]   a1;
  logic [W-1:0]   b0;
  logic [W-1:0]   b1;
  logic [K*W-1:0] r0;
  logic [K*W-1:0] r1;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   y0;
  logic [W-1:0]   y1;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output a0, a1, b0, b1, r0, r1,
    output in_valid, out_ready,
    input  in_ready, y0, y1, out_valid
  );

  modport slave (
    input  a0, a1, b0, b1, r0, r1,
    input  in_valid, out_ready,
    output in_ready, y0, y1, out_valid
  );
endinterface

// File: rtl/hpc1_and_pipe.sv
// K serially composed HPC1 masked AND gadgets with a global stall enable.
// Operand b travels down a delay line so every stage multiplies by the same b.
module hpc1_and_pipe #(
  parameter int W = 4,
  parameter int K = 2
) (
  input logic             clk,
  input logic             rst_n,
  hpc1_and_pipe_if.slave  bus
);

  logic         en;
  logic [W-1:0] sx0 [K+1];
  logic [W-1:0] sx1 [K+1];
  logic         sv  [K+1];
  logic [W-1:0] sb0 [K];
  logic [W-1:0] sb1 [K];

  logic [W-1:0] y0_d, y0_q;
  logic [W-1:0] y1_d, y1_q;
  logic         out_valid_d, out_valid_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign sx0[0]       = bus.a0;
  assign sx1[0]       = bus.a1;
  assign sv[0]        = bus.in_valid;
  assign sb0[0]       = bus.b0;
  assign sb1[0]       = bus.b1;

  for (genvar k = 0; k < K; k++) begin : g_stage
    logic [W-1:0] r0k, r1k;
    logic [W-1:0] xa0_d, xa0_q, xa1_d, xa1_q;
    logic [W-1:0] c0_d, c0_q, c1_d, c1_q;
    logic [W-1:0] i1_d, i1_q, p1_d, p1_q;
    logic [W-1:0] i2_d, i2_q, p4_d, p4_q;
    logic         va_d, va_q, vb_d, vb_q;

    assign r0k = bus.r0[k*W +: W];
    assign r1k = bus.r1[k*W +: W];

    always_comb begin
      xa0_d = xa0_q;
      xa1_d = xa1_q;
      c0_d  = c0_q;
      c1_d  = c1_q;
      va_d  = va_q;
      i1_d  = i1_q;
      p1_d  = p1_q;
      i2_d  = i2_q;
      p4_d  = p4_q;
      vb_d  = vb_q;
      if (en) begin
        xa0_d = sx0[k];
        xa1_d = sx1[k];
        c0_d  = sb0[k] ^ r0k;
        c1_d  = sb1[k] ^ r0k;
        va_d  = sv[k];
        i1_d  = (xa0_q & c1_q) ^ r1k;
        p1_d  = xa0_q & c0_q;
        i2_d  = (xa1_q & c0_q) ^ r1k;
        p4_d  = xa1_q & c1_q;
        vb_d  = va_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        xa0_q <= '0;
        xa1_q <= '0;
        c0_q  <= '0;
        c1_q  <= '0;
        va_q  <= 1'b0;
        i1_q  <= '0;
        p1_q  <= '0;
        i2_q  <= '0;
        p4_q  <= '0;
        vb_q  <= 1'b0;
      end else begin
        xa0_q <= xa0_d;
        xa1_q <= xa1_d;
        c0_q  <= c0_d;
        c1_q  <= c1_d;
        va_q  <= va_d;
        i1_q  <= i1_d;
        p1_q  <= p1_d;
        i2_q  <= i2_d;
        p4_q  <= p4_d;
        vb_q  <= vb_d;
      end
    end

    // Share compression reads registers only; next stage re-registers it.
    assign sx0[k+1] = i1_q ^ p1_q;
    assign sx1[k+1] = i2_q ^ p4_q;
    assign sv[k+1]  = vb_q;

    if (k < K-1) begin : g_bdly
      logic [W-1:0] ba0_d, ba0_q, ba1_d, ba1_q;
      logic [W-1:0] bb0_d, bb0_q, bb1_d, bb1_q;

      always_comb begin
        ba0_d = ba0_q;
        ba1_d = ba1_q;
        bb0_d = bb0_q;
        bb1_d = bb1_q;
        if (en) begin
          ba0_d = sb0[k];
          ba1_d = sb1[k];
          bb0_d = ba0_q;
          bb1_d = ba1_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ba0_q <= '0;
          ba1_q <= '0;
          bb0_q <= '0;
          bb1_q <= '0;
        end else begin
          ba0_q <= ba0_d;
          ba1_q <= ba1_d;
          bb0_q <= bb0_d;
          bb1_q <= bb1_d;
        end
      end

      assign sb0[k+1] = bb0_q;
      assign sb1[k+1] = bb1_q;
    end
  end

  always_comb begin
    y0_d        = y0_q;
    y1_d        = y1_q;
    out_valid_d = out_valid_q;
    if (en) begin
      y0_d        = sx0[K];
      y1_d        = sx1[K];
      out_valid_d = sv[K];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q        <= '0;
      y1_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y0        = y0_q;
  assign bus.y1        = y1_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_hpc1_and_pipe.sv
// Directed bench for hpc1_and_pipe (W=4, K=2): latency, masking, stall,
// mid-flight reset and exhaustive lane checks.
module tb_hpc1_and_pipe;
  localparam int W = 4;
  localparam int K = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hpc1_and_pipe_if #(.W(W), .K(K)) bus ();

  hpc1_and_pipe #(.W(W), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [3:0] b0,
                       input logic [3:0] b1);
    bus.in_valid = v;
    bus.a0 = a0;
    bus.a1 = a1;
    bus.b0 = b0;
    bus.b1 = b1;
    bus.r0 = 8'($urandom);
    bus.r1 = 8'($urandom);
  endtask

  task automatic drive_ab(input logic v, input logic [3:0] a,
                          input logic [3:0] b);
    logic [3:0] ma, mb;
    ma = 4'($urandom);
    mb = 4'($urandom);
    drive(v, ma, a ^ ma, mb, b ^ mb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    #3;
    checks++;
    if (bus.y0 !== 4'h0) begin
      failures++;
      $display("FAIL rst_y0 got=%b exp=0000", bus.y0);
    end
    checks++;
    if (bus.y1 !== 4'h0) begin
      failures++;
      $display("FAIL rst_y1 got=%b exp=0000", bus.y1);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_ov got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'b0110, 4'b1101, 4'b0011, 4'b0101);
    for (int s = 1; s <= 6; s++) begin
      step();
      checks++;
      if (bus.out_valid !== (s == 5)) begin
        failures++;
        $display("FAIL basic_ov s=%0d got=%b exp=%b", s, bus.out_valid, s == 5);
      end
      if (s == 5) begin
        checks++;
        if ((bus.y0 ^ bus.y1) !== 4'b0010) begin
          failures++;
          $display("FAIL basic_y got=%b exp=0010", bus.y0 ^ bus.y1);
        end
      end
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_masks();
    logic [3:0] ys [16];
    int ndiff;
    for (int s = 0; s <= 21; s++) begin
      if (s > 0) step();
      if (s >= 1) begin
        checks++;
        if (bus.out_valid !== (s >= 5 && s <= 20)) begin
          failures++;
          $display("FAIL mask_ov s=%0d got=%b", s, bus.out_valid);
        end
      end
      if (s >= 5 && s <= 20) begin
        ys[s-5] = bus.y0;
        checks++;
        if ((bus.y0 ^ bus.y1) !== 4'b0010) begin
          failures++;
          $display("FAIL mask_y s=%0d got=%b exp=0010", s, bus.y0 ^ bus.y1);
        end
      end
      if (s < 16) drive(1'b1, 4'b0110, 4'b1101, 4'b0011, 4'b0101);
      else drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    ndiff = 0;
    for (int i = 1; i < 16; i++) if (ys[i] !== ys[0]) ndiff++;
    checks++;
    if (ndiff == 0) begin
      failures++;
      $display("FAIL mask_indep got=%0d differing y0 exp>=1", ndiff);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ex [8];
    logic [3:0] a, b;
    for (int s = 0; s <= 13; s++) begin
      if (s > 0) step();
      if (s >= 1) begin
        checks++;
        if (bus.out_valid !== (s >= 5 && s <= 12)) begin
          failures++;
          $display("FAIL b2b_ov s=%0d got=%b", s, bus.out_valid);
        end
      end
      if (s >= 5 && s <= 12) begin
        checks++;
        if ((bus.y0 ^ bus.y1) !== ex[s-5]) begin
          failures++;
          $display("FAIL b2b_y s=%0d got=%b exp=%b", s, bus.y0 ^ bus.y1, ex[s-5]);
        end
      end
      if (s < 8) begin
        a = 4'($urandom);
        b = 4'($urandom);
        ex[s] = a & b;
        drive_ab(1'b1, a, b);
      end else begin
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      end
    end
  endtask

  task automatic test_stall();
    logic       mv [5];
    logic [3:0] md [5];
    logic [3:0] sy0, sy1, a, b;
    logic       en_m, v;
    int         acc, got;
    acc = 0;
    got = 0;
    sy0 = '0;
    sy1 = '0;
    for (int i = 0; i < 5; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    for (int s = 0; s <= 22; s++) begin
      if (s > 0) step();
      checks++;
      if (bus.out_valid !== mv[4]) begin
        failures++;
        $display("FAIL stall_ov s=%0d got=%b exp=%b", s, bus.out_valid, mv[4]);
      end
      if (mv[4]) begin
        checks++;
        if ((bus.y0 ^ bus.y1) !== md[4]) begin
          failures++;
          $display("FAIL stall_y s=%0d got=%b exp=%b", s, bus.y0 ^ bus.y1, md[4]);
        end
      end
      if (s >= 7 && s <= 9) begin
        checks++;
        if (bus.y0 !== sy0 || bus.y1 !== sy1) begin
          failures++;
          $display("FAIL stall_hold s=%0d got=%b/%b exp=%b/%b",
                   s, bus.y0, bus.y1, sy0, sy1);
        end
      end
      if (s == 6) begin
        sy0 = bus.y0;
        sy1 = bus.y1;
      end
      v = (s <= 11);
      a = 4'($urandom);
      b = 4'($urandom);
      drive_ab(v, a, b);
      bus.out_ready = !(s >= 6 && s <= 8);
      #1;
      en_m = !mv[4] || bus.out_ready;
      checks++;
      if (bus.in_ready !== en_m) begin
        failures++;
        $display("FAIL stall_in_ready s=%0d got=%b exp=%b", s, bus.in_ready, en_m);
      end
      if (bus.out_valid && bus.out_ready) got++;
      if (en_m) begin
        for (int i = 4; i > 0; i--) begin
          mv[i] = mv[i-1];
          md[i] = md[i-1];
        end
        mv[0] = v;
        md[0] = a & b;
        if (v) acc++;
      end
    end
    bus.out_ready = 1'b1;
    checks++;
    if (acc !== 9 || got !== 9) begin
      failures++;
      $display("FAIL stall_count got acc=%0d out=%0d exp=9/9", acc, got);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] a, b, e;
    for (int s = 0; s <= 5; s++) begin
      if (s > 0) step();
      drive_ab(1'b1, 4'($urandom), 4'($urandom));
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre_ov got=%b exp=1", bus.out_valid);
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y0 !== 4'h0 || bus.y1 !== 4'h0) begin
      failures++;
      $display("FAIL rmid_async got ov=%b y0=%b y1=%b exp=0/0000/0000",
               bus.out_valid, bus.y0, bus.y1);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rmid_stale s=%0d got=%b exp=0", s, bus.out_valid);
      end
    end
    a = 4'b1010;
    b = 4'b1100;
    e = 4'b1000;
    drive_ab(1'b1, a, b);
    for (int s = 1; s <= 6; s++) begin
      step();
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      checks++;
      if (bus.out_valid !== (s == 5)) begin
        failures++;
        $display("FAIL rmid_lat s=%0d got=%b exp=%b", s, bus.out_valid, s == 5);
      end
      if (s == 5) begin
        checks++;
        if ((bus.y0 ^ bus.y1) !== e) begin
          failures++;
          $display("FAIL rmid_y got=%b exp=%b", bus.y0 ^ bus.y1, e);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] ex [256];
    logic [7:0] p;
    for (int s = 0; s <= 261; s++) begin
      if (s > 0) step();
      if (s >= 5 && s <= 260) begin
        checks++;
        if (bus.out_valid !== 1'b1 || (bus.y0 ^ bus.y1) !== ex[s-5]) begin
          failures++;
          $display("FAIL exh pair=%0d got ov=%b y=%b exp ov=1 y=%b",
                   s - 5, bus.out_valid, bus.y0 ^ bus.y1, ex[s-5]);
        end
      end
      if (s == 261) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL exh_tail got=%b exp=0", bus.out_valid);
        end
      end
      if (s < 256) begin
        p = 8'(s);
        ex[s] = p[7:4] & p[3:0];
        drive_ab(1'b1, p[7:4], p[3:0]);
      end else begin
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_masks();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpc1_and_pipe.md
HPC1_AND_PIPE -- requirements
Module: hpc1_and_pipe

Interface
REQ-001 SHALL have parameter W, default 4: number of independent bit-lanes, valid range 1..64.
REQ-002 SHALL have parameter K, default 2: number of composed HPC1 AND gadgets, valid range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports a0, a1, input, W bits each: Boolean shares of operand a, where a = a0^a1.
REQ-006 SHALL have ports b0, b1, input, W bits each: Boolean shares of operand b, where b = b0^b1.
REQ-007 SHALL have port r0, input, K*W bits: refresh randomness; slice k is [k*W +: W].
REQ-008 SHALL have port r1, input, K*W bits: multiplication randomness; slice k is [k*W +: W].
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake.
REQ-010 SHALL have ports y0, y1, output, W bits each, registered: result shares.
REQ-011 SHALL have ports out_valid (output, 1 bit, registered) and out_ready (input, 1 bit): output handshake.

Function
REQ-012 SHALL instantiate K gadget stages in series, each 2 register levels; the output register adds one more level, giving a pipeline depth D=2K+1.
REQ-013 Stage 0 operand x SHALL be (a0,a1); the operand x of stage k>0 SHALL be the share pair output by stage k-1.
REQ-014 b0/b1 SHALL be carried down a delay line alongside the data, so stage k always uses the b captured with the same transaction.
REQ-015 Stage k level A SHALL register x0 and x1, plus c0=b0^r0[k] and c1=b1^r0[k], using the r0 slice k present on the cycle level A loads.
REQ-016 Stage k level B SHALL register:
- i1 = (x0&c1)^r1[k]
- p1 = x0&c0
- i2 = (x1&c0)^r1[k]
- p4 = x1&c1
using the r1 slice k present on the cycle level B loads.
REQ-017 Stage k output SHALL be (i1^p1, i2^p4), combinational from the level-B registers only; no unregistered cross-share path may span two levels.
REQ-018 The output register SHALL load y0/y1 from the stage K-1 output.
REQ-019 Functional invariant: y0^y1 SHALL equal a&b for the transaction (b&b=b, so the result is independent of K).
REQ-020 Global advance enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-021 Each level SHALL carry a valid bit; when en=1 all levels shift by one; when en=0 all data, valid and b-delay registers hold.
REQ-022 A transaction SHALL be accepted on any edge where in_valid && en; if in_valid=0 while en=1, a bubble (valid=0) enters level 0.
REQ-023 A transaction accepted at edge t with no stalls SHALL have out_valid=1 and y0/y1 valid after edge t+2K.
REQ-024 Throughput SHALL be one transaction per cycle when out_ready=1 continuously.
REQ-025 Bubbles SHALL NOT be collapsed during a stall; pipeline order SHALL be preserved.
REQ-026 While stalled, y0, y1 and out_valid SHALL hold stable until out_ready=1.
REQ-027 Randomness SHALL be consumed only on advancing edges; r0/r1 values on stalled cycles SHALL have no effect.
REQ-028 Lanes SHALL be fully independent; no bit-lane mixes into another.

Reset
REQ-029 While rst_n=0, all data registers, b-delay registers, valid bits, y0, y1 and out_valid SHALL be 0, asynchronously.
REQ-030 in_ready SHALL read 1 during and immediately after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight transactions; no stale out_valid may follow deassertion.
REQ-032 The first transaction accepted after reset SHALL emerge after exactly 2K+1 levels, as in REQ-023.

Verification (W=4, K=2)
REQ-033 Basic: a0=0110, a1=1101, b0=0011, b1=0101, random r, out_ready=1, single accept at edge t -> out_valid=1 after edge t+4, y0^y1=0010.
REQ-034 Mask independence: same a/b, 16 different r0/r1 sets -> y0^y1=0010 every time, and y0 differs across at least two sets.
REQ-035 Back-to-back: 8 consecutive random transactions -> 8 consecutive out_valid cycles, in order, each y0^y1 = a&b.
REQ-036 Stall: out_ready=0 for 3 cycles while full -> in_ready=0, y0/y1/out_valid frozen; resume -> no loss, no duplication, correct results.
REQ-037 Reset mid-flight: pulse rst_n low with 3 transactions in flight -> y0=y1=0 and out_valid=0 immediately, and no output until a new accept plus 2K+1 levels.
REQ-038 Exhaustive lane check: all 256 (a,b) 4-bit pairs with random sharings -> y0^y1 = a&b for every pair.
